// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter.
//
// Serializes one byte per valid/ready handshake onto the tx line as a
// standard asynchronous frame: start bit (0), 8 data bits LSB first,
// optional even parity bit, one stop bit (1). Every bit is held for
// CLKS_PER_BIT clock cycles, timed by an internal cycle counter.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> even parity bit between data bit 7 and the stop bit (11-bit frame)
//   undefined -> no parity state or logic (10-bit frame)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   tx_data   byte to send, sampled only on the handshake
//   tx_valid  host presents a byte on tx_data
//   tx_ready  block accepts a byte this cycle (registered)
//   tx        serial line, idle high (registered)
//   busy      frame in progress (registered)

module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          bit_done;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // consumed while the data bits go out.
    logic          parity_q, parity_d;
`endif

    assign bit_done = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d   = tx_data;
                    bit_idx_d = 3'd0;
                    cnt_d     = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // versions line up with the state they describe.
        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Drives directed and random bytes through the handshake and compares the
// serial line cycle by cycle against a frame model built from the byte
// (start, data LSB first, optional even parity, stop). Honors the
// UART_TX_PARITY_EN macro for the expected frame shape.

module tb_uart_tx;

    localparam int CLKS_PER_BIT = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NUM_BITS  = 11;
    localparam bit PARITY_ON = 1'b1;
`else
    localparam int NUM_BITS  = 10;
    localparam bit PARITY_ON = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int testCount;
    int failCount;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference frame: bit position idx of the frame carrying data.
    function automatic logic frameBit(input logic [7:0] data, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
        if (PARITY_ON && idx == 9) return ^data;
        return 1'b1;
    endfunction

    // Called at a sample point (1 time unit after a rising edge) with the
    // block idle. Presents data, checks every cycle of the frame, and ends
    // at the sample point just after the frame completes. While busy, the
    // inputs are scrambled (and tx_valid optionally pulsed) to show they
    // are ignored. keepValid leaves tx_valid high for a chained transfer.
    task automatic applyStimulus(input logic [7:0] data, input bit noise, input bit keepValid);
        checkOutput("ready_before_handshake", tx_ready, 1'b1);
        tx_data  = data;
        tx_valid = 1'b1;
        for (int j = 0; j < NUM_BITS * CLKS_PER_BIT; j++) begin
            @(posedge clk);
            #1;
            checkOutput("tx_bit", tx, frameBit(data, j / CLKS_PER_BIT));
            checkOutput("busy_in_frame", busy, 1'b1);
            checkOutput("ready_in_frame", tx_ready, 1'b0);
            tx_data  = 8'($urandom);
            tx_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("tx_after_frame", tx, 1'b1);
        checkOutput("busy_after_frame", busy, 1'b0);
        checkOutput("ready_after_frame", tx_ready, 1'b1);
        tx_valid = keepValid;
    endtask

    // Line must stay idle with no frame starting.
    task automatic idleCheck(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_tx", tx, 1'b1);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_ready", tx_ready, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] rndByte;
        bit         chain;
        testCount = 0;
        failCount = 0;
        rstn      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;

        // Power-on reset.
        @(posedge clk);
        #1;
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_ready", tx_ready, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_first_edge", tx_ready, 1'b1);
        checkOutput("tx_idle_first_edge", tx, 1'b1);

        // Basic frame.
        applyStimulus(8'hA5, 1'b0, 1'b0);
        idleCheck(3);

        // Back-to-back with tx_valid held high.
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        idleCheck(2);

        // Parity-sensitive bytes (odd and even popcount).
        applyStimulus(8'h07, 1'b0, 1'b0);
        idleCheck(1);
        applyStimulus(8'h03, 1'b0, 1'b0);
        idleCheck(1);

        // Inputs change while busy; nothing queued.
        applyStimulus(8'h81, 1'b1, 1'b0);
        idleCheck(4);

        // Reset in the middle of data bit 3 of 0x55.
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (4 * CLKS_PER_BIT + 1) @(posedge clk);
        #1;
        checkOutput("pre_reset_bit3", tx, 1'b0);
        checkOutput("pre_reset_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_tx", tx, 1'b1);
        checkOutput("async_reset_ready", tx_ready, 1'b0);
        checkOutput("async_reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("held_reset_tx", tx, 1'b1);
        checkOutput("held_reset_ready", tx_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", tx_ready, 1'b1);
        checkOutput("busy_after_reset", busy, 1'b0);
        checkOutput("tx_after_reset", tx, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idleCheck(1);

        // Random bytes, random chaining, gaps and busy-time noise.
        chain = 1'b0;
        for (int n = 0; n < 12; n++) begin
            rndByte = 8'($urandom);
            chain   = 1'($urandom_range(0, 1));
            applyStimulus(rndByte, 1'($urandom_range(0, 1)), chain);
            if (!chain) idleCheck(int'($urandom_range(1, 5)));
        end
        if (chain) applyStimulus(8'($urandom), 1'b0, 1'b0);
        idleCheck(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
